// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID pipeline register,
// drives the instruction memory read port and applies stall / ID-stage
// redirects. Memory read is combinational, so an instruction fetched at pc
// lands in IF/ID on the next posedge.
module if_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [15:0]      branch_offset,
  input  logic             jump,
  input  logic [25:0]      jump_index,
  input  logic [31:0]      imem_data,
  output logic [31:0]      imem_addr,
  output logic             imem_ren,
  output logic [31:0]      pc,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc4,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // The low PC bits are forced to zero so the PC stays word-aligned even
  // if a misaligned reset vector is supplied.
  localparam logic [31:0]      PC_START = {PC_RESET[31:2], 2'b00};

  logic [31:0]      r_pc;
  logic [31:0]      r_if_id_instr;
  logic [31:0]      r_if_id_pc4;
  logic             r_if_id_valid;
  logic [CNT_W-1:0] r_fetch_count;
  logic [CNT_W-1:0] r_stall_count;

  logic             w_redirect;
  logic [31:0]      w_pc4;
  logic [31:0]      w_boffset;
  logic [31:0]      w_btarget;
  logic [31:0]      w_jtarget;
  logic [31:0]      w_target;

  // A bubble in IF/ID carries no real branch/jump, so redirect needs a valid slot.
  assign w_redirect = (branch_taken | jump) & r_if_id_valid;
  assign w_pc4      = r_pc + 32'd4;
  assign w_boffset  = {{14{branch_offset[15]}}, branch_offset, 2'b00};
  assign w_btarget  = r_if_id_pc4 + w_boffset;
  assign w_jtarget  = {r_if_id_pc4[31:28], jump_index, 2'b00};
  assign w_target   = jump ? w_jtarget : w_btarget;

  assign imem_addr   = {2'b00, r_pc[31:2]};
  assign imem_ren    = ~reset;
  assign pc          = r_pc;
  assign if_id_instr = r_if_id_instr;
  assign if_id_pc4   = r_if_id_pc4;
  assign if_id_valid = r_if_id_valid;
  assign fetch_count = r_fetch_count;
  assign stall_count = r_stall_count;

  // PC / IF/ID update: stall holds everything (redirect deferred until the
  // branch operands settle), redirect flushes one bubble, else fetch.
  // imem_data is only sampled on the fetch path so garbage seen during a
  // stall or redirect never reaches IF/ID.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc          <= PC_START;
      r_if_id_instr <= 32'h0000_0000;
      r_if_id_pc4   <= 32'h0000_0000;
      r_if_id_valid <= 1'b0;
      r_fetch_count <= '0;
      r_stall_count <= '0;
    end else if (stall) begin
      r_stall_count <= r_stall_count + CNT_ONE;
    end else if (w_redirect) begin
      r_pc          <= w_target;
      r_if_id_instr <= 32'h0000_0000;
      r_if_id_valid <= 1'b0;
    end else begin
      r_pc          <= w_pc4;
      r_if_id_instr <= imem_data;
      r_if_id_pc4   <= w_pc4;
      r_if_id_valid <= 1'b1;
      r_fetch_count <= r_fetch_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: each step pushes the model's expected state
// into a scoreboard queue, and the entry is popped and compared just after
// the posedge that produces it.
module tb_if_stage;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] fc;
    logic [31:0] sc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        reset_hi = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_offset = 16'h0;
  logic        jump = 1'b0;
  logic [25:0] jump_index = 26'h0;
  logic        poison = 1'b0;

  logic [31:0] imem_data, imem_addr, pc, if_id_instr, if_id_pc4, fetch_count, stall_count;
  logic        imem_ren, if_id_valid;

  logic [31:0] imem_data_hi, imem_addr_hi, pc_hi, if_id_instr_hi, if_id_pc4_hi, fetch_count_hi, stall_count_hi;
  logic        imem_ren_hi, if_id_valid_hi;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  logic [31:0] m_pc, m_instr, m_pc4, m_fc, m_sc;
  logic        m_valid;

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] waddr);
    return (waddr == 32'd0) ? 32'h2001_0005 : {8'hA5, waddr[23:0]};
  endfunction

  // Poison stands in for X data: it is driven whenever the DUT must not capture.
  assign imem_data    = poison ? 32'hDEAD_BEEF : mem_word(imem_addr);
  assign imem_data_hi = {8'h5A, imem_addr_hi[23:0]};

  if_stage #(.PC_RESET(32'h0000_0000), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .jump(jump), .jump_index(jump_index),
    .imem_data(imem_data), .imem_addr(imem_addr), .imem_ren(imem_ren), .pc(pc),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
    .fetch_count(fetch_count), .stall_count(stall_count)
  );

  if_stage #(.PC_RESET(32'h1000_0004), .CNT_W(32)) dut_hi (
    .clock(clock), .reset(reset_hi), .stall(stall), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .jump(jump), .jump_index(jump_index),
    .imem_data(imem_data_hi), .imem_addr(imem_addr_hi), .imem_ren(imem_ren_hi), .pc(pc_hi),
    .if_id_instr(if_id_instr_hi), .if_id_pc4(if_id_pc4_hi), .if_id_valid(if_id_valid_hi),
    .fetch_count(fetch_count_hi), .stall_count(stall_count_hi)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    m_fc = 32'h0; m_sc = 32'h0;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_instr"}, if_id_instr, 32'h0);
    chk({tag, "_pc4"}, if_id_pc4, 32'h0);
    chk({tag, "_valid"}, {31'h0, if_id_valid}, 32'h0);
    chk({tag, "_fc"}, fetch_count, 32'h0);
    chk({tag, "_sc"}, stall_count, 32'h0);
    chk({tag, "_addr"}, imem_addr, 32'h0);
    chk({tag, "_ren"}, {31'h0, imem_ren}, 32'h0);
  endtask

  // Called one time unit after a posedge (or at time 0); reset lands mid-cycle.
  task automatic apply_reset(input string tag);
    poison = 1'b0;
    stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    reset = 1'b1;
    #1;
    model_clear();
    chk_cleared(tag);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk({tag, "_ren_rel"}, {31'h0, imem_ren}, 32'h1);
  endtask

  task automatic step(input logic st, input logic bt, input logic [15:0] off,
                      input logic jp, input logic [25:0] idx);
    exp_t        e;
    logic        red;
    logic [31:0] sx;
    stall = st; branch_taken = bt; branch_offset = off; jump = jp; jump_index = idx;
    red    = (bt | jp) & m_valid;
    poison = st | red;
    if (st) begin
      m_sc = m_sc + 32'd1;
    end else if (red) begin
      sx      = {{16{off[15]}}, off};
      m_pc    = jp ? {m_pc4[31:28], idx, 2'b00} : m_pc4 + (sx << 2);
      m_instr = 32'h0;
      m_valid = 1'b0;
    end else begin
      m_instr = mem_word({2'b00, m_pc[31:2]});
      m_pc    = m_pc + 32'd4;
      m_pc4   = m_pc;
      m_valid = 1'b1;
      m_fc    = m_fc + 32'd1;
    end
    e = '{pc: m_pc, instr: m_instr, pc4: m_pc4, valid: m_valid, fc: m_fc, sc: m_sc};
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    chk("sb_pc", pc, e.pc);
    chk("sb_instr", if_id_instr, e.instr);
    if (e.valid) chk("sb_pc4", if_id_pc4, e.pc4);
    chk("sb_valid", {31'h0, if_id_valid}, {31'h0, e.valid});
    chk("sb_fc", fetch_count, e.fc);
    chk("sb_sc", stall_count, e.sc);
    chk("sb_addr", imem_addr, {2'b00, e.pc[31:2]});
    chk("sb_ren", {31'h0, imem_ren}, 32'h1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
  endtask

  initial begin
    model_clear();
    apply_reset("rst0");

    // First fetch
    run(1);
    chk("tp1_pc", pc, 32'd4);
    chk("tp1_instr", if_id_instr, 32'h2001_0005);
    chk("tp1_pc4", if_id_pc4, 32'd4);
    chk("tp1_valid", {31'h0, if_id_valid}, 32'h1);
    chk("tp1_fc", fetch_count, 32'd1);

    // Five sequential fetches
    run(4);
    chk("seq_pc", pc, 32'd20);
    chk("seq_fc", fetch_count, 32'd5);
    chk("seq_sc", stall_count, 32'd0);
    chk("seq_addr", imem_addr, 32'd5);

    // Stall at pc=8 with poisoned memory data
    apply_reset("rst1");
    run(2);
    chk("stl_pc_pre", pc, 32'd8);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 1'b0, 26'h0);
    chk("stl_pc", pc, 32'd8);
    chk("stl_instr", if_id_instr, mem_word(32'd1));
    chk("stl_sc", stall_count, 32'd3);
    run(1);
    chk("stl_rel_pc", pc, 32'd12);
    chk("stl_rel_instr", if_id_instr, mem_word(32'd2));

    // Backward branch from if_id_pc4=16
    run(1);
    chk("br_pc4", if_id_pc4, 32'd16);
    step(1'b0, 1'b1, 16'hFFFC, 1'b0, 26'h0);
    chk("br_pc", pc, 32'd0);
    chk("br_valid", {31'h0, if_id_valid}, 32'h0);
    chk("br_instr", if_id_instr, 32'h0);
    run(1);
    chk("br_resume_instr", if_id_instr, 32'h2001_0005);

    // Same branch held under stall, redirect only once stall drops
    run(3);
    chk("brs_pc4", if_id_pc4, 32'd16);
    step(1'b1, 1'b1, 16'hFFFC, 1'b0, 26'h0);
    step(1'b1, 1'b1, 16'hFFFC, 1'b0, 26'h0);
    chk("brs_hold_pc", pc, 32'd16);
    chk("brs_hold_valid", {31'h0, if_id_valid}, 32'h1);
    step(1'b0, 1'b1, 16'hFFFC, 1'b0, 26'h0);
    chk("brs_pc", pc, 32'd0);
    chk("brs_valid", {31'h0, if_id_valid}, 32'h0);

    // Jump vs branch priority on the high-reset instance
    reset_hi = 1'b0;
    run(1);
    chk("hi_pc4", if_id_pc4_hi, 32'h1000_0008);
    chk("hi_valid", {31'h0, if_id_valid_hi}, 32'h1);
    step(1'b0, 1'b1, 16'h0010, 1'b1, 26'h40);
    chk("jmp_pc_hi", pc_hi, 32'h1000_0100);
    chk("jmp_valid_hi", {31'h0, if_id_valid_hi}, 32'h0);
    chk("jmp_pc_lo", pc, 32'h0000_0100);
    step(1'b0, 1'b1, 16'h0010, 1'b1, 26'h40);
    chk("jmp_ign_pc_hi", pc_hi, 32'h1000_0104);
    chk("jmp_ign_pc_lo", pc, 32'h0000_0104);

    // Reset mid-stall at pc=40
    apply_reset("rst2");
    run(10);
    chk("mid_pc", pc, 32'd40);
    step(1'b1, 1'b0, 16'h0, 1'b0, 26'h0);
    step(1'b1, 1'b0, 16'h0, 1'b0, 26'h0);
    chk("mid_sc", stall_count, 32'd2);
    stall = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    chk_cleared("midrst");
    @(negedge clock);
    stall = 1'b0;
    reset = 1'b0;
    #1;
    run(2);
    chk("post_pc", pc, 32'd8);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline. Owns the PC and the IF/ID pipeline register.
- Drives the instruction Memory read port.
- Consumes the OR of the load-use and branch-hazard Stall signals, plus the branch/jump redirect resolved in ID.
- Produces instruction, PC+4 and a valid bit for the decode stage.

Parameters:
PC_RESET, 32'h0000_0000, byte address loaded into PC on reset
CNT_W, 32, width of fetch and stall performance counters

Ports:
clock  input  1  pipeline clock; all state updates on posedge
reset  input  1  asynchronous, active-high; clears all state
stall  input  1  hold PC and IF/ID (OR of hazard-unit Stall outputs)
branch_taken  input  1  ID-stage branch resolved taken
branch_offset  input  16  signed word offset from IF/ID instruction imm field
jump  input  1  ID-stage j/jal decoded
jump_index  input  26  instr[25:0] of IF/ID instruction
imem_data  input  32  instruction Memory dout
imem_addr  output  32  word address to Memory = {2'b00, pc[31:2]}
imem_ren  output  1  Memory read enable
pc  output  32  current fetch byte address
if_id_instr  output  32  IF/ID instruction register
if_id_pc4  output  32  IF/ID PC+4 register
if_id_valid  output  1  IF/ID holds a real instruction
fetch_count  output  CNT_W  valid instructions latched into IF/ID
stall_count  output  CNT_W  cycles held by stall

Behaviour:
- Reset (async, any time, including mid-stall or mid-redirect):
  - pc=PC_RESET; if_id_instr=0 (NOP); if_id_pc4=0; if_id_valid=0; both counters=0.
  - imem_ren=0 while reset is high, 1 otherwise (combinational). imem_addr tracks pc combinationally.
- Redirect qualification: redirect = (branch_taken | jump) & if_id_valid. Branch/jump inputs are ignored when IF/ID holds a bubble.
- Targets, 32-bit, wrap modulo 2^32:
  - btarget = if_id_pc4 + (sign_extend(branch_offset) << 2).
  - jtarget = {if_id_pc4[31:28], jump_index, 2'b00}.
  - jump has priority over branch_taken if both are asserted.
- Next-state priority per posedge:
  1. stall=1: pc, if_id_* hold; stall_count+1. Redirect is suppressed, because the branch operands are not final. No delay slot is lost — the redirect is re-evaluated when stall drops.
  2. redirect=1: pc<=target; if_id_instr<=0; if_id_valid<=0 (one-bubble flush, no delay slot); if_id_pc4 holds its value (don't-care).
  3. otherwise: pc<=pc+4; if_id_instr<=imem_data; if_id_pc4<=pc+4; if_id_valid<=1; fetch_count+1.
- Memory read is combinational: imem_data for pc is sampled in the same cycle. Fetch latency is 1 cycle, pc to if_id_instr.
- Counter overflow: counters wrap to 0 with no saturation.
- pc[1:0] is always 00; all targets are word-aligned by construction.
- No X propagation allowed: an X on imem_data while stall=1 or redirect=1 must not be captured.

Test Plan:
- Reset then release, imem returns 32'h2001_0005 at word 0 → next posedge pc=4, if_id_instr=32'h2001_0005, if_id_pc4=4, if_id_valid=1, fetch_count=1.
- Sequential run of 5 cycles from PC_RESET=0 → pc=20, fetch_count=5, stall_count=0, imem_addr=5.
- stall=1 for 3 cycles at pc=8 → pc stays 8, IF/ID unchanged, stall_count=3; on release pc=12.
- branch_taken=1, if_id_pc4=16, offset=16'hFFFC → pc=0, if_id_valid=0, if_id_instr=0 next cycle; fetch resumes from 0.
  - Same with stall=1 concurrently → no redirect until stall drops, then pc=0.
- jump=1 and branch_taken=1 together, if_id_pc4=32'h1000_0008, index=26'h40 → pc=32'h1000_0100 (jump wins).
  - With if_id_valid=0 → ignored, pc+4.
- Assert reset mid-stall at pc=40 → pc, IF/ID, counters clear immediately without waiting for a clock edge; imem_ren=0 during reset.
